axi_lite_slave_core: RTL and testbench



---
 rtl/axi_lite_slave_core.sv | 151 +++++++++++++++
 tb/tb_axi_lite_slave_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_core.sv
// rtl/axi_lite_slave_core.sv - AXI-lite-style 16x4 register-file slave with display drive (option: AXI_SLV_SEVSEG_EN)
module axi_lite_slave_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ms_araddr,
  input  logic       ms_arvalid,
  output logic       sm_arready,
  output logic [3:0] sm_rdata,
  output logic       sm_rvalid,
  input  logic       ms_rready,
  input  logic [3:0] ms_awaddr,
  input  logic       ms_awvalid,
  output logic       sm_awready,
  input  logic [3:0] ms_wdata,
  input  logic       ms_wvalid,
  output logic       sm_wready,
  output logic [7:0] disp_hex_r
);

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  rstate_t    state_q, state_d;
  logic [3:0] rdata_q, rdata_d;
  logic [3:0] last_read_q, last_read_d;
  logic       aw_full_q, aw_full_d;
  logic       w_full_q, w_full_d;
  logic [3:0] aw_addr_q, aw_addr_d;
  logic [3:0] w_data_q, w_data_d;
  logic [3:0] mem_q [16];
  logic [3:0] mem_d [16];

  logic       write_commit;

  // Readies and valids come straight from state so no ms_* input reaches an sm_* output.
  assign sm_arready   = (state_q == R_IDLE);
  assign sm_rvalid    = (state_q == R_DATA);
  assign sm_rdata     = rdata_q;
  assign sm_awready   = !aw_full_q;
  assign sm_wready    = !w_full_q;
  assign write_commit = aw_full_q && w_full_q;

  // Read FSM: capture data on AR, hold it through R, copy it to the display latch on R.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    last_read_d = last_read_q;
    case (state_q)
      R_IDLE: begin
        if (ms_arvalid) begin
          // mem_q is the pre-commit contents, giving read-before-write on a collision.
          rdata_d = mem_q[ms_araddr];
          state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (ms_rready) begin
          last_read_d = rdata_q;
          state_d     = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Write path: address and data captured independently, committed once both are held.
  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    for (int i = 0; i < 16; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (write_commit) begin
      mem_d[aw_addr_q] = w_data_q;
      aw_full_d        = 1'b0;
      w_full_d         = 1'b0;
    end else begin
      if (ms_awvalid && !aw_full_q) begin
        aw_addr_d = ms_awaddr;
        aw_full_d = 1'b1;
      end
      if (ms_wvalid && !w_full_q) begin
        w_data_d = ms_wdata;
        w_full_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any pending read or half-accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= R_IDLE;
      rdata_q     <= '0;
      last_read_q <= '0;
      aw_full_q   <= 1'b0;
      w_full_q    <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      last_read_q <= last_read_d;
      aw_full_q   <= aw_full_d;
      w_full_q    <= w_full_d;
      aw_addr_q   <= aw_addr_d;
      w_data_q    <= w_data_d;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef AXI_SLV_SEVSEG_EN
  function automatic logic [6:0] sevseg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Decimal point mirrors a pending read; segments show the last completed read.
  assign disp_hex_r = {sm_rvalid, sevseg(last_read_q)};
`else
  // Raw nibble display with the pending-read flag next to it.
  assign disp_hex_r = {3'b000, sm_rvalid, last_read_q};
`endif

endmodule

// File: tb/tb_axi_lite_slave_core.sv
// tb/tb_axi_lite_slave_core.sv - self-checking bench for axi_lite_slave_core
module tb_axi_lite_slave_core;

  logic       clk;
  logic       rst_n;
  logic [3:0] ms_araddr;
  logic       ms_arvalid;
  logic       sm_arready;
  logic [3:0] sm_rdata;
  logic       sm_rvalid;
  logic       ms_rready;
  logic [3:0] ms_awaddr;
  logic       ms_awvalid;
  logic       sm_awready;
  logic [3:0] ms_wdata;
  logic       ms_wvalid;
  logic       sm_wready;
  logic [7:0] disp_hex_r;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];

  axi_lite_slave_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ms_araddr  (ms_araddr),
    .ms_arvalid (ms_arvalid),
    .sm_arready (sm_arready),
    .sm_rdata   (sm_rdata),
    .sm_rvalid  (sm_rvalid),
    .ms_rready  (ms_rready),
    .ms_awaddr  (ms_awaddr),
    .ms_awvalid (ms_awvalid),
    .sm_awready (sm_awready),
    .ms_wdata   (ms_wdata),
    .ms_wvalid  (ms_wvalid),
    .sm_wready  (sm_wready),
    .disp_hex_r (disp_hex_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_disp(input logic [3:0] v, input logic rv);
`ifdef AXI_SLV_SEVSEG_EN
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return {rv, tbl[v]};
`else
    return {3'b000, rv, v};
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_arready"}, {7'b0, sm_arready}, 8'h01);
    check({name, "_rvalid"},  {7'b0, sm_rvalid},  8'h00);
    check({name, "_awready"}, {7'b0, sm_awready}, 8'h01);
    check({name, "_wready"},  {7'b0, sm_wready},  8'h01);
  endtask

  // Called at a negedge: AW and W together, then wait for the commit edge.
  task automatic do_write(input logic [3:0] a, input logic [3:0] d);
    ms_awaddr = a; ms_wdata = d; ms_awvalid = 1'b1; ms_wvalid = 1'b1;
    @(negedge clk);
    ms_awvalid = 1'b0; ms_wvalid = 1'b0;
    check("wr_awready_busy", {7'b0, sm_awready}, 8'h00);
    @(negedge clk);
    check("wr_readies_back", {6'b0, sm_awready, sm_wready}, 8'h03);
  endtask

  task automatic start_read(input logic [3:0] a, input logic [3:0] e);
    ms_araddr = a; ms_arvalid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    ms_arvalid = 1'b0;
    check("rd_rvalid_up", {6'b0, sm_rvalid, sm_arready}, 8'h02);
  endtask

  task automatic finish_read;
    logic [3:0] e;
    ms_rready = 1'b1;
    @(negedge clk);
    ms_rready = 1'b0;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL rd_scoreboard_empty actual=%0d required=1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      check("rd_data", {4'b0, sm_rdata}, {4'b0, e});
      check("rd_done_flags", {6'b0, sm_rvalid, sm_arready}, 8'h01);
      check("rd_disp", disp_hex_r, exp_disp(e, 1'b0));
    end
  endtask

  typedef struct {
    bit         is_write;
    logic [3:0] addr;
    logic [3:0] data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 4'h5, 4'hA};
    vecs[1] = '{1'b0, 4'h5, 4'hA};
    vecs[2] = '{1'b1, 4'h0, 4'h7};
    vecs[3] = '{1'b1, 4'hF, 4'hC};
    vecs[4] = '{1'b0, 4'h0, 4'h7};
    vecs[5] = '{1'b0, 4'hF, 4'hC};
    vecs[6] = '{1'b0, 4'h3, 4'h0};
    vecs[7] = '{1'b1, 4'h5, 4'h1};
    vecs[8] = '{1'b0, 4'h5, 4'h1};
    vecs[9] = '{1'b0, 4'hA, 4'h0};

    rst_n = 1'b0;
    ms_araddr = '0; ms_arvalid = 1'b0; ms_rready = 1'b0;
    ms_awaddr = '0; ms_awvalid = 1'b0; ms_wdata = '0; ms_wvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rdata", {4'b0, sm_rdata}, 8'h00);
    check("reset_disp", disp_hex_r, exp_disp(4'h0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven basic writes and reads.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        start_read(vecs[i].addr, vecs[i].data);
        check("tbl_disp_dp", {7'b0, disp_hex_r[7]}, exp_disp(4'h0, 1'b1) >> 7);
        finish_read();
      end
    end

    // Out-of-order write: data waits three cycles for its address.
    ms_wdata = 4'h3; ms_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ooo_wready_low", {6'b0, sm_awready, sm_wready}, 8'h02);
    end
    ms_wvalid = 1'b0;
    ms_awaddr = 4'h9; ms_awvalid = 1'b1;
    @(negedge clk);
    ms_awvalid = 1'b0;
    @(negedge clk);
    check("ooo_committed", {6'b0, sm_awready, sm_wready}, 8'h03);
    start_read(4'h9, 4'h3);
    finish_read();

    // Read backpressure: data and valid held while ms_rready stays low.
    start_read(4'h9, 4'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold", {sm_rvalid, sm_arready, 2'b0, sm_rdata}, 8'h83);
    end
    finish_read();

    // Collision: AR to addr 2 on the very edge its new value commits.
    do_write(4'h2, 4'h1);
    ms_awaddr = 4'h2; ms_wdata = 4'hF; ms_awvalid = 1'b1; ms_wvalid = 1'b1;
    @(negedge clk);
    ms_awvalid = 1'b0; ms_wvalid = 1'b0;
    start_read(4'h2, 4'h1);
    finish_read();
    start_read(4'h2, 4'hF);
    finish_read();

    // Reset mid-operation: half-accepted write and an open read are discarded.
    ms_awaddr = 4'h4; ms_awvalid = 1'b1;
    @(negedge clk);
    ms_awvalid = 1'b0;
    check("mid_aw_held", {6'b0, sm_awready, sm_wready}, 8'h01);
    ms_araddr = 4'h9; ms_arvalid = 1'b1;
    @(negedge clk);
    ms_arvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_rdata", {4'b0, sm_rdata}, 8'h00);
    check("async_reset_disp", disp_hex_r, exp_disp(4'h0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ms_wdata = 4'h5; ms_wvalid = 1'b1;
    @(negedge clk);
    ms_wvalid = 1'b0;
    @(negedge clk);
    check("post_reset_w_waits", {6'b0, sm_awready, sm_wready}, 8'h02);
    start_read(4'h4, 4'h0);
    finish_read();
    start_read(4'h9, 4'h0);
    finish_read();
    ms_awaddr = 4'h6; ms_awvalid = 1'b1;
    @(negedge clk);
    ms_awvalid = 1'b0;
    @(negedge clk);
    start_read(4'h6, 4'h5);
    finish_read();

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
